// File: rtl/serial_digit_adder.sv
// serial_digit_adder: multi-cycle adder/subtractor processing DIGIT bits per
// clock, LSB digit first, with a rippled carry between digits. Operands enter
// through a valid/ready port; sum, carry-out and signed overflow leave through
// a second valid/ready port. One operation in flight at a time.
module serial_digit_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Reject geometries where the digits do not tile the operand exactly.
  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_digit_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_q;      // operand A, shifted right one digit per RUN cycle
  logic [WIDTH-1:0] b_q;      // effective operand B (inverted for subtract)
  logic             carry;    // carry rippling between digits
  logic [WIDTH-1:0] shadow;   // partial sum, digits shifted in from the top
  logic [CW-1:0]    cnt;      // digit index 0..N-1

  logic [DIGIT-1:0]       a_d;
  logic [DIGIT-1:0]       b_d;
  logic [DIGIT:0]         digit_full;
  logic [WIDTH+DIGIT-1:0] shift_cat;
  logic [WIDTH-1:0]       shadow_next;
  logic                   carry_msb;
  logic                   last_digit;

  // Digit adder for the current digit and the shifted shadow value.
  always_comb begin
    a_d         = a_q[DIGIT-1:0];
    b_d         = b_q[DIGIT-1:0];
    digit_full  = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, carry};
    shift_cat   = {digit_full[DIGIT-1:0], shadow};
    shadow_next = shift_cat[WIDTH+DIGIT-1:DIGIT];
    // Sum bit = a ^ b ^ carry_in, so the carry into the digit MSB falls out
    // of the XOR without a separate partial adder.
    carry_msb   = a_d[DIGIT-1] ^ b_d[DIGIT-1] ^ digit_full[DIGIT-1];
    last_digit  = (cnt == LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)   state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand capture, digit-serial datapath and registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      shadow <= '0;
      cnt    <= '0;
      sum    <= '0;
      Cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (in_valid) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? ~Cin : Cin;
          end
        end
        RUN: begin
          a_q    <= a_q >> DIGIT;
          b_q    <= b_q >> DIGIT;
          carry  <= digit_full[DIGIT];
          shadow <= shadow_next;
          cnt    <= cnt + CW'(1);
          if (last_digit) begin
            sum  <= shadow_next;
            Cout <= digit_full[DIGIT];
            ovf  <= carry_msb ^ digit_full[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_digit_adder.sv
// Self-checking bench for serial_digit_adder: directed vectors on the default
// (8,2) geometry plus random sweeps on (8,8), (8,1) and (16,4).
module tb_serial_digit_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: returns {ovf, Cout, sum[15:0]} for a w-bit operation.
  function automatic logic [17:0] ref_model(input int w, input logic [15:0] ra,
                                            input logic [15:0] rb, input logic rcin,
                                            input logic rsub);
    int unsigned mask, lmask, be, c0, total, cm, co;
    logic [17:0] r;
    mask  = (32'd1 << w) - 1;
    lmask = (32'd1 << (w - 1)) - 1;
    be    = rsub ? (~{16'd0, rb} & mask) : ({16'd0, rb} & mask);
    c0    = rsub ? {31'd0, ~rcin} : {31'd0, rcin};
    total = ({16'd0, ra} & mask) + be + c0;
    co    = (total >> w) & 1;
    cm    = ((({16'd0, ra} & lmask) + (be & lmask) + c0) >> (w - 1)) & 1;
    r     = {cm[0] ^ co[0], co[0], 16'(total & mask)};
    return r;
  endfunction

  // ---------------- directed DUT, WIDTH=8 DIGIT=2 ----------------
  logic       m_rst_n, m_in_valid, m_in_ready, m_cin, m_sub;
  logic       m_out_valid, m_out_ready, m_cout, m_ovf;
  logic [7:0] m_a, m_b, m_sum;

  serial_digit_adder #(.WIDTH(8), .DIGIT(2)) u_main (
    .clk(clk), .rst_n(m_rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .Cin(m_cin), .sub(m_sub), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .sum(m_sum), .Cout(m_cout), .ovf(m_ovf)
  );

  task automatic m_send(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input logic ts);
    int g = 0;
    @(negedge clk);
    while (!m_in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("in_ready before send", 32'(m_in_ready), 32'd1);
    m_a = ta; m_b = tb_; m_cin = tc; m_sub = ts; m_in_valid = 1'b1;
    @(posedge clk);
    #1 m_in_valid = 1'b0;
  endtask

  task automatic m_wait(output int lat);
    lat = 0;
    while (!m_out_valid && lat < 64) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic m_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                      input logic tc, input logic ts, input logic [7:0] e_sum,
                      input logic e_cout, input logic e_ovf);
    int lat;
    m_send(ta, tb_, tc, ts);
    m_wait(lat);
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " sum"}, 32'(m_sum), 32'(e_sum));
    check({tag, " Cout"}, 32'(m_cout), 32'(e_cout));
    check({tag, " ovf"}, 32'(m_ovf), 32'(e_ovf));
    m_out_ready = 1'b1;
    @(posedge clk);
    #1 m_out_ready = 1'b0;
  endtask

  // ---------------- parameter sweep DUTs ----------------
  localparam int SW [3] = '{8, 8, 16};
  localparam int SD [3] = '{8, 1, 4};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int W = SW[gi];
    localparam int D = SD[gi];
    localparam int N = W / D;

    logic         s_rst_n, s_in_valid, s_in_ready, s_cin, s_sub;
    logic         s_out_valid, s_out_ready, s_cout, s_ovf;
    logic [W-1:0] s_a, s_b, s_sum;
    logic         done;

    serial_digit_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk(clk), .rst_n(s_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .a(s_a), .b(s_b), .Cin(s_cin), .sub(s_sub), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .sum(s_sum), .Cout(s_cout), .ovf(s_ovf)
    );

    initial begin
      int lat;
      logic [17:0] exp;
      done = 1'b0;
      s_rst_n = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
      s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) s_rst_n = 1'b1;
      for (int k = 0; k < 1000; k++) begin
        @(negedge clk);
        check($sformatf("sweep%0d in_ready", gi), 32'(s_in_ready), 32'd1);
        s_a = W'($urandom); s_b = W'($urandom);
        s_cin = 1'($urandom); s_sub = k[0];
        s_in_valid = 1'b1;
        exp = ref_model(W, 16'(s_a), 16'(s_b), s_cin, s_sub);
        @(posedge clk);
        #1 s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 64) begin
          @(posedge clk);
          #1 lat++;
        end
        check($sformatf("sweep%0d latency", gi), 32'(lat), 32'(N));
        check($sformatf("sweep%0d sum", gi), 32'(s_sum), 32'(exp[15:0]));
        check($sformatf("sweep%0d Cout", gi), 32'(s_cout), 32'(exp[16]));
        check($sformatf("sweep%0d ovf", gi), 32'(s_ovf), 32'(exp[17]));
        s_out_ready = 1'b1;
        @(posedge clk);
        #1 s_out_ready = 1'b0;
      end
      done = 1'b1;
    end
  end

  // ---------------- directed sequence and summary ----------------
  initial begin
    int lat;
    int budget;
    m_rst_n = 1'b0; m_in_valid = 1'b0; m_out_ready = 1'b0;
    m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset sum", 32'(m_sum), 32'd0);
    check("reset Cout", 32'(m_cout), 32'd0);
    check("reset ovf", 32'(m_ovf), 32'd0);
    check("reset out_valid", 32'(m_out_valid), 32'd0);
    m_rst_n = 1'b1;
    @(posedge clk);
    #1 check("in_ready after reset", 32'(m_in_ready), 32'd1);

    m_op("add ovf 5A+33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1);
    m_op("wrap FF+01",    8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    m_op("cin FF+FF+1",   8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    m_op("sub 10-20",     8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    m_op("sub 80-01",     8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    m_op("sub 05-02-1",   8'h05, 8'h02, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0);

    // Back-pressure: F2+34 = 0x126, held in DONE for three cycles.
    m_send(8'hF2, 8'h34, 1'b0, 1'b0);
    m_wait(lat);
    check("bp latency", 32'(lat), 32'd4);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        m_a = 8'hFF; m_b = 8'hFF; m_in_valid = 1'b1;
      end
      @(posedge clk);
      #1 m_in_valid = 1'b0;
      check("bp out_valid held", 32'(m_out_valid), 32'd1);
      check("bp in_ready low", 32'(m_in_ready), 32'd0);
      check("bp sum stable", 32'(m_sum), 32'h26);
      check("bp Cout stable", 32'(m_cout), 32'd1);
      check("bp ovf stable", 32'(m_ovf), 32'd0);
    end
    m_out_ready = 1'b1;
    @(posedge clk);
    #1 m_out_ready = 1'b0;
    check("bp release out_valid", 32'(m_out_valid), 32'd0);
    check("bp release in_ready", 32'(m_in_ready), 32'd1);
    check("bp sum kept", 32'(m_sum), 32'h26);
    check("bp Cout kept", 32'(m_cout), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("bp pulse ignored", 32'(m_in_ready), 32'd1);
    end

    // Reset during RUN cycle 2.
    m_send(8'h77, 8'h11, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 m_rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrun in_ready", 32'(m_in_ready), 32'd1);
    check("midrun out_valid", 32'(m_out_valid), 32'd0);
    check("midrun sum", 32'(m_sum), 32'd0);
    check("midrun Cout", 32'(m_cout), 32'd0);
    check("midrun ovf", 32'(m_ovf), 32'd0);
    m_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 check("midrun no result", 32'(m_out_valid), 32'd0);
    end
    m_op("after reset 01+01", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

    budget = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && budget < 60000) begin
      @(posedge clk);
      budget++;
    end
    check("sweeps finished", 32'(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done),
          32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_digit_adder.md
# serial_digit_adder

Parametrised multi-cycle adder/subtractor: adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB digit first, with a rippled carry between digits. It is the sequential, handshaked successor of the combinational ripple adders, for datapaths that trade latency for area. Operands enter through a valid/ready input port. Sum, carry-out and signed overflow leave through a valid/ready output port.

## Interface
- WIDTH, 8: operand and sum width. WIDTH ≥ 1.
- DIGIT, 2: bits processed per cycle. 1 ≤ DIGIT ≤ WIDTH. WIDTH % DIGIT == 0, checked at elaboration.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- Cin  in  1  carry-in in add mode; borrow-in in subtract mode.
- sub  in  1  0 = a + b + Cin; 1 = a − b − Cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- Cout  out  1  carry out of the MSB. In subtract mode, 1 = no borrow.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- N = WIDTH/DIGIT digit steps per operation.
- State machine has three states: IDLE, RUN, DONE.
  - IDLE → RUN on in_valid && in_ready.
  - RUN → DONE after N RUN cycles.
  - DONE → IDLE on out_valid && out_ready.
- in_ready = 1 only in IDLE. out_valid = 1 only in DONE. There is no overlap of operations.
- On accept, register a, b_eff and c0:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? ~Cin : Cin.
  - The input bus is not sampled again until the next accept.
- Each RUN cycle k (k = 0..N−1):
  - digit k sum = a[k] + b_eff[k] + carry.
  - Shift the DIGIT-bit result into the internal sum shadow register.
  - Update the carry.
  - The digit counter runs 0..N−1 and is reset in IDLE.
- On the last digit:
  - Capture carry into MSB and carry out of MSB; ovf = their XOR.
  - Transfer the shadow register to sum, Cout and ovf.
- sum, Cout and ovf are registered outputs. They change only on the RUN→DONE edge and hold until the next RUN→DONE edge, including after the handshake.
- Inputs while busy: in_valid is ignored outside IDLE and the operand buses are don't-care.
- Back-pressure: DONE holds indefinitely while out_ready = 0.
- out_ready while not in DONE: ignored.
- DIGIT == WIDTH: N = 1, giving a single RUN cycle.
- DIGIT == 1: bit-serial operation.

## Timing
- Reset, any edge with rst_n = 0:
  - state = IDLE; counter, carry and shadow register = 0.
  - sum = 0, Cout = 0, ovf = 0, out_valid = 0.
  - in_ready = 1 from the first edge with rst_n = 1.
- Reset mid-RUN or in DONE: the operation is discarded and no result is emitted.
- Latency: operands accepted at edge T → out_valid = 1 and result stable after edge T+N.
- Earliest result handshake is edge T+N+1. in_ready rises after that edge.
- Throughput: one operation per N+2 cycles with out_ready held at 1.
- in_ready and out_valid are decoded directly from the state register. There is no combinational path from any input to any output.

## Test plan
- **Add with signed overflow.** WIDTH = 8, DIGIT = 2; a = 0x5A, b = 0x33, Cin = 0, sub = 0, accepted at edge T.
  - Expect out_valid after edge T+4, sum = 0x8D, Cout = 0, ovf = 1.
- **Carry wrap and carry-in.**
  - 0xFF + 0x01, Cin = 0 → sum = 0x00, Cout = 1, ovf = 0.
  - 0xFF + 0xFF, Cin = 1 → sum = 0xFF, Cout = 1, ovf = 0.
- **Subtract.**
  - 0x10 − 0x20, Cin = 0 → sum = 0xF0, Cout = 0, ovf = 0.
  - 0x80 − 0x01 → sum = 0x7F, Cout = 1, ovf = 1.
  - 0x05 − 0x02, Cin = 1 → sum = 0x02, Cout = 1.
- **Back-pressure.** Hold out_ready = 0 for 3 cycles in DONE.
  - sum, Cout and ovf stay stable; in_ready stays 0.
  - An in_valid pulse with new operands is ignored.
  - Raise out_ready → IDLE on the next edge; outputs keep their values.
- **Reset mid-RUN.** Drive rst_n = 0 at RUN cycle 2.
  - Next edge: IDLE; all outputs 0.
  - No out_valid is produced.
  - A subsequent 0x01 + 0x01 → 0x02 with correct latency.
- **Parameter sweep.** Cover (8,8), (8,1) and (16,4).
  - Latency is exactly N = 1, 8 and 4 cycles respectively.
  - 1000 random operands per configuration match a reference model (sum, Cout, ovf) in both modes.
